keypad_entry: RTL and testbench

- Scans a 4x4 matrix keypad, debounces it, and assembles four hex key presses into a 16-bit guess for the answer checker and display.
- Sits directly upstream of the answer-compare and display stages in the memorization game.
- Drives the keypad columns, samples the rows, and presents value/valueReady to downstream logic.

---
 rtl/game_pkg.sv | 28 ++
 rtl/keypad_scanner.sv | 110 +++++++++++
 rtl/keypad_entry.sv | 145 ++++++++++++++
 tb/tb_keypad_entry.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the memorization game: digit count, keypad map and
// the key debounce states used by the entry logic.
package game_pkg;

    // Number of hex digits in one entry; value is 4*DIGITS bits wide.
    localparam int DIGITS = 4;

    // Keypad legend indexed by {row, col}; columns run left to right.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    typedef enum logic [1:0] {
        DEB_IDLE,
        DEB_CAND,
        DEB_HELD,
        DEB_REL
    } deb_state_t;

    // Key code at a given matrix position.
    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 active-low keypad. Drives one column low per slot,
// samples the synchronized rows at the end of each slot and classifies each
// full scan as no key, a single key, or several keys.
module keypad_scanner
    import game_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       scanDone,
    output logic [3:0] scanKey,
    output logic       scanValid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       r_rows_s1;
    logic [3:0]       r_rows_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    // Low contacts seen so far this scan, saturating at 2 (2 means "several").
    logic [1:0]       r_hits;
    logic [3:0]       r_idx;

    logic       w_slot_end;
    logic       w_scan_end;
    logic [1:0] w_sample_hits;
    logic [1:0] w_sample_row;
    logic [1:0] w_tot_hits;
    logic [3:0] w_tot_idx;

    assign w_slot_end = (r_div == DIV_LAST);
    assign w_scan_end = w_slot_end && (r_col == 2'd3);

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rows_s1 <= 4'hF;
            r_rows_s2 <= 4'hF;
        end else begin
            r_rows_s1 <= rows;
            r_rows_s2 <= r_rows_s1;
        end
    end

    // Slot divider and column pointer; column advances at the end of each slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= '0;
            r_col <= 2'd0;
        end else if (w_slot_end) begin
            r_div <= '0;
            r_col <= r_col + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Count low rows in the current sample and remember which one it was.
    always_comb begin
        w_sample_hits = 2'd0;
        w_sample_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!r_rows_s2[r]) begin
                w_sample_row  = 2'(r);
                w_sample_hits = (w_sample_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    // Fold the current sample into the per-scan tally.
    always_comb begin
        w_tot_hits = r_hits;
        w_tot_idx  = r_idx;
        if (w_sample_hits != 2'd0) begin
            if (r_hits == 2'd0) begin
                w_tot_hits = w_sample_hits;
                w_tot_idx  = {w_sample_row, r_col};
            end else begin
                w_tot_hits = 2'd2;
            end
        end
    end

    // Keep the tally across slots and clear it once the scan has been reported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hits <= 2'd0;
            r_idx  <= 4'd0;
        end else if (w_slot_end) begin
            if (r_col == 2'd3) begin
                r_hits <= 2'd0;
                r_idx  <= 4'd0;
            end else begin
                r_hits <= w_tot_hits;
                r_idx  <= w_tot_idx;
            end
        end
    end

    assign cols      = ~(4'b0001 << r_col);
    assign scanDone  = w_scan_end;
    assign scanValid = w_scan_end && (w_tot_hits == 2'd1);
    assign scanKey   = key_lookup(w_tot_idx[3:2], w_tot_idx[1:0]);

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry: debounces scanner results into single key presses and shifts
// up to DIGITS accepted hex keys into a 16-bit guess for downstream logic.
module keypad_entry
    import game_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        ack,
    output logic [15:0] value,
    output logic        valueReady,
    output logic        keyValid,
    output logic [3:0]  keyCode
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam int DIG_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Counter value at which one more matching scan completes the debounce.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [DIG_W-1:0] DIG_FULL = DIG_W'(DIGITS);
    localparam logic             ONE_SCAN = (DEBOUNCE_SCANS <= 1);

    logic       w_scan_done;
    logic       w_scan_valid;
    logic [3:0] w_scan_key;
    logic       w_accept;

    deb_state_t       r_state;
    logic [3:0]       r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic             r_kv;
    logic [3:0]       r_code;
    logic [15:0]      r_value;
    logic [DIG_W-1:0] r_count;
    logic             r_ready;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .rows      (rows),
        .cols      (cols),
        .scanDone  (w_scan_done),
        .scanKey   (w_scan_key),
        .scanValid (w_scan_valid)
    );

    // A press is accepted on the scan that completes the run of matching scans.
    always_comb begin
        w_accept = 1'b0;
        if (w_scan_done && w_scan_valid) begin
            case (r_state)
                DEB_IDLE: w_accept = ONE_SCAN;
                DEB_CAND: w_accept = (w_scan_key == r_cand) && (r_cnt >= CNT_LAST);
                default:  w_accept = 1'b0;
            endcase
        end
    end

    // Debounce FSM, stepped once per scan; also registers the key report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DEB_IDLE;
            r_cand  <= 4'd0;
            r_cnt   <= '0;
            r_kv    <= 1'b0;
            r_code  <= 4'd0;
        end else begin
            r_kv <= w_accept;
            if (w_accept) begin
                r_code <= w_scan_key;
            end
            if (w_scan_done) begin
                case (r_state)
                    DEB_IDLE: begin
                        if (w_scan_valid) begin
                            r_cand  <= w_scan_key;
                            r_cnt   <= CNT_ONE;
                            r_state <= w_accept ? DEB_HELD : DEB_CAND;
                        end
                    end
                    DEB_CAND: begin
                        if (!w_scan_valid) begin
                            r_state <= DEB_IDLE;
                        end else if (w_scan_key != r_cand) begin
                            r_cand <= w_scan_key;
                            r_cnt  <= CNT_ONE;
                        end else if (w_accept) begin
                            r_state <= DEB_HELD;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    DEB_HELD: begin
                        // No auto-repeat: keys while held are ignored.
                        if (!w_scan_valid) begin
                            r_cnt   <= CNT_ONE;
                            r_state <= ONE_SCAN ? DEB_IDLE : DEB_REL;
                        end
                    end
                    DEB_REL: begin
                        if (w_scan_valid) begin
                            r_state <= DEB_HELD;
                        end else if (r_cnt >= CNT_LAST) begin
                            r_state <= DEB_IDLE;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    default: r_state <= DEB_IDLE;
                endcase
            end
        end
    end

    // Digit shift register; ack clears the entry and takes priority over a new key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= 16'h0000;
            r_count <= '0;
            r_ready <= 1'b0;
        end else if (ack) begin
            r_value <= 16'h0000;
            r_count <= '0;
            r_ready <= 1'b0;
        end else if (w_accept && (r_count < DIG_FULL)) begin
            r_value <= {r_value[11:0], w_scan_key};
            r_count <= r_count + DIG_W'(1);
            r_ready <= (r_count == DIG_LAST);
        end
    end

    assign value      = r_value;
    assign valueReady = r_ready;
    assign keyValid   = r_kv;
    assign keyCode    = r_code;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: keypad matrix model, directed per-scan vector
// table, reset corner cases and randomized scans against a reference model.
`timescale 1ns/1ps
module tb_keypad_entry;

    localparam int SD   = 4;
    localparam int DB   = 2;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        ack = 1'b0;
    logic [15:0] value;
    logic        valueReady;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic [15:0] pressed = 16'h0000;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rows       (rows),
        .cols       (cols),
        .ack        (ack),
        .value      (value),
        .valueReady (valueReady),
        .keyValid   (keyValid),
        .keyCode    (keyCode)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic string layout_row(input int r);
        case (r)
            0: return "123A";
            1: return "456B";
            2: return "789C";
            default: return "0FED";
        endcase
    endfunction

    function automatic logic [3:0] key_of(input int idx);
        string s;
        byte   ch;
        s  = layout_row(idx / 4);
        ch = s[idx % 4];
        return (ch >= 8'h41) ? 4'(ch - 8'd55) : 4'(ch - 8'd48);
    endfunction

    function automatic logic [15:0] mask_of(input string keys);
        logic [15:0] m;
        string       s;
        m = 16'h0000;
        for (int k = 0; k < keys.len(); k++)
            for (int i = 0; i < 16; i++) begin
                s = layout_row(i / 4);
                if (s[i % 4] == keys[k]) m[i] = 1'b1;
            end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One full scan from a scan start: hold mask, optionally ack during the boundary cycle.
    task automatic do_scan(input logic [15:0] mask, input logic a, output int stray,
                           output logic kv, output logic [3:0] code,
                           output logic [15:0] val, output logic rdy);
        stray   = 0;
        pressed = mask;
        for (int i = 1; i <= SCAN; i++) begin
            @(negedge clk);
            if (i < SCAN && keyValid) stray++;
            if (i == SCAN - 1) ack = a;
        end
        kv   = keyValid;
        code = keyCode;
        val  = value;
        rdy  = valueReady;
        ack  = 1'b0;
    endtask

    // Reference model: history of per-scan results (-1 = nothing usable).
    int          m_hist[$];
    bit          m_armed;
    int          m_none_run;
    int          m_count;
    logic [15:0] m_value;
    logic [3:0]  m_code;

    task automatic model_reset();
        m_hist.delete();
        m_armed    = 1'b1;
        m_none_run = 0;
        m_count    = 0;
        m_value    = 16'h0000;
        m_code     = 4'h0;
    endtask

    task automatic model_scan(input logic [15:0] mask, input logic a, output logic kv);
        int res;
        bit acc;
        res = -1;
        if ($countones(mask) == 1)
            for (int i = 0; i < 16; i++) if (mask[i]) res = int'(key_of(i));
        m_hist.push_back(res);
        acc = 1'b0;
        if (res < 0) begin
            m_none_run++;
            if (!m_armed && m_none_run >= DB) m_armed = 1'b1;
        end else begin
            m_none_run = 0;
            if (m_armed && m_hist.size() >= DB) begin
                acc = 1'b1;
                for (int j = 1; j <= DB; j++)
                    if (m_hist[m_hist.size() - j] != res) acc = 1'b0;
            end
        end
        if (acc) begin
            m_armed = 1'b0;
            m_code  = res[3:0];
        end
        if (a) begin
            m_value = 16'h0000;
            m_count = 0;
        end else if (acc && m_count < 4) begin
            m_value = {m_value[11:0], res[3:0]};
            m_count++;
        end
        kv = acc;
    endtask

    typedef struct {
        logic [15:0] mask;
        logic        a;
        logic        kv;
        logic [3:0]  code;
        logic [15:0] val;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string keys, input logic a, input logic kv,
                       input logic [3:0] code, input logic [15:0] val, input logic rdy);
        vec_t v;
        v.mask = mask_of(keys);
        v.a    = a;
        v.kv   = kv;
        v.code = code;
        v.val  = val;
        v.rdy  = rdy;
        tbl.push_back(v);
    endtask

    initial begin
        int          stray;
        logic        kv;
        logic [3:0]  code;
        logic [15:0] val;
        logic        rdy;
        logic        ekv;
        logic [3:0]  exp_cols;
        logic [15:0] cur;
        int          remain;
        int          sel;
        int          ka;
        int          kb;
        logic        a_flag;

        // Reset state and column rotation.
        repeat (5) @(negedge clk);
        check("rst_cols", cols, 4'b1110);
        check("rst_value", value, 16'h0000);
        check("rst_ready", valueReady, 1'b0);
        check("rst_kv", keyValid, 1'b0);
        check("rst_code", keyCode, 4'h0);
        rst = 1'b1;
        for (int j = 0; j < SCAN; j++) begin
            exp_cols = ~(4'b0001 << (j / 4));
            check($sformatf("cols_c%0d", j), cols, exp_cols);
            @(negedge clk);
        end

        // Directed scans: single press, 4-digit entry, overflow, ack, bounce, multi-key, ack+accept.
        add("5", 0, 0, 4'h0, 16'h0000, 0);
        add("5", 0, 1, 4'h5, 16'h0005, 0);
        add("5", 0, 0, 4'h5, 16'h0005, 0);
        add("5", 0, 0, 4'h5, 16'h0005, 0);
        add("",  0, 0, 4'h5, 16'h0005, 0);
        add("",  0, 0, 4'h5, 16'h0005, 0);
        add("",  1, 0, 4'h5, 16'h0000, 0);
        add("1", 0, 0, 4'h5, 16'h0000, 0);
        add("1", 0, 1, 4'h1, 16'h0001, 0);
        add("",  0, 0, 4'h1, 16'h0001, 0);
        add("",  0, 0, 4'h1, 16'h0001, 0);
        add("A", 0, 0, 4'h1, 16'h0001, 0);
        add("A", 0, 1, 4'hA, 16'h001A, 0);
        add("",  0, 0, 4'hA, 16'h001A, 0);
        add("",  0, 0, 4'hA, 16'h001A, 0);
        add("0", 0, 0, 4'hA, 16'h001A, 0);
        add("0", 0, 1, 4'h0, 16'h01A0, 0);
        add("",  0, 0, 4'h0, 16'h01A0, 0);
        add("",  0, 0, 4'h0, 16'h01A0, 0);
        add("F", 0, 0, 4'h0, 16'h01A0, 0);
        add("F", 0, 1, 4'hF, 16'h1A0F, 1);
        add("",  0, 0, 4'hF, 16'h1A0F, 1);
        add("",  0, 0, 4'hF, 16'h1A0F, 1);
        add("3", 0, 0, 4'hF, 16'h1A0F, 1);
        add("3", 0, 1, 4'h3, 16'h1A0F, 1);
        add("",  0, 0, 4'h3, 16'h1A0F, 1);
        add("",  1, 0, 4'h3, 16'h0000, 0);
        for (int b = 0; b < 3; b++) begin
            add("7", 0, 0, 4'h3, 16'h0000, 0);
            add("",  0, 0, 4'h3, 16'h0000, 0);
        end
        add("7", 0, 0, 4'h3, 16'h0000, 0);
        add("7", 0, 1, 4'h7, 16'h0007, 0);
        add("",  0, 0, 4'h7, 16'h0007, 0);
        add("",  0, 0, 4'h7, 16'h0007, 0);
        for (int b = 0; b < 5; b++) add("28", 0, 0, 4'h7, 16'h0007, 0);
        add("",  0, 0, 4'h7, 16'h0007, 0);
        add("4", 0, 0, 4'h7, 16'h0007, 0);
        add("4", 1, 1, 4'h4, 16'h0000, 0);
        add("",  0, 0, 4'h4, 16'h0000, 0);
        add("",  0, 0, 4'h4, 16'h0000, 0);
        add("4", 0, 0, 4'h4, 16'h0000, 0);
        add("4", 0, 1, 4'h4, 16'h0004, 0);
        add("",  0, 0, 4'h4, 16'h0004, 0);
        add("",  0, 0, 4'h4, 16'h0004, 0);
        add("9", 0, 0, 4'h4, 16'h0004, 0);
        add("9", 0, 1, 4'h9, 16'h0049, 0);

        foreach (tbl[i]) begin
            do_scan(tbl[i].mask, tbl[i].a, stray, kv, code, val, rdy);
            check($sformatf("tbl%0d_stray", i), stray, 0);
            check($sformatf("tbl%0d_kv", i), kv, tbl[i].kv);
            check($sformatf("tbl%0d_code", i), code, tbl[i].code);
            check($sformatf("tbl%0d_value", i), val, tbl[i].val);
            check($sformatf("tbl%0d_ready", i), rdy, tbl[i].rdy);
        end

        // Reset in the middle of a scan while "9" is still held.
        pressed = mask_of("9");
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_value", value, 16'h0000);
        check("midrst_cols", cols, 4'b1110);
        check("midrst_code", keyCode, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        do_scan(mask_of("9"), 1'b0, stray, kv, code, val, rdy);
        check("midrst_s1_kv", kv, 1'b0);
        check("midrst_s1_value", val, 16'h0000);
        do_scan(mask_of("9"), 1'b0, stray, kv, code, val, rdy);
        check("midrst_s2_kv", kv, 1'b1);
        check("midrst_s2_code", code, 4'h9);
        check("midrst_s2_value", val, 16'h0009);

        // Randomized scans against the reference model, from a fresh reset.
        pressed = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        remain = 0;
        cur    = 16'h0000;
        for (int s = 0; s < 160; s++) begin
            if (remain == 0) begin
                sel = $urandom_range(0, 99);
                if (sel < 50) begin
                    cur    = 16'h0001 << $urandom_range(0, 15);
                    remain = $urandom_range(1, 4);
                end else if (sel < 85) begin
                    cur    = 16'h0000;
                    remain = $urandom_range(1, 3);
                end else begin
                    ka     = $urandom_range(0, 15);
                    kb     = (ka + $urandom_range(1, 15)) % 16;
                    cur    = (16'h0001 << ka) | (16'h0001 << kb);
                    remain = $urandom_range(1, 3);
                end
            end
            a_flag = ($urandom_range(0, 9) == 0);
            model_scan(cur, a_flag, ekv);
            do_scan(cur, a_flag, stray, kv, code, val, rdy);
            check($sformatf("rnd%0d_stray", s), stray, 0);
            check($sformatf("rnd%0d_kv", s), kv, ekv);
            check($sformatf("rnd%0d_code", s), code, m_code);
            check($sformatf("rnd%0d_value", s), val, m_value);
            check($sformatf("rnd%0d_ready", s), rdy, (m_count == 4));
            remain--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
